// File: rtl/vga_write_bridge.sv
// Bridges the CPU character-write strobe into the VGA character RAM write port.
// Valid writes are buffered in a small show-ahead FIFO and drained with a valid/ready handshake.
module vga_write_bridge #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned POS_MAX = 1199,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     videoflag,
  input  logic [DATA_W-1:0]        vga_pos,
  input  logic [DATA_W-1:0]        vga_char,
  output logic [DATA_W-1:0]        vram_addr,
  output logic [DATA_W-1:0]        vram_data,
  output logic                     vram_we,
  input  logic                     vram_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     range_err,
  output logic [7:0]               drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]     FullCount = CW'(DEPTH);
  localparam logic [DATA_W-1:0] PosMax    = DATA_W'(POS_MAX);

  logic [DATA_W-1:0] pos_mem_q  [DEPTH];
  logic [DATA_W-1:0] char_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              flag_q;
  logic              overflow_q, range_err_q;
  logic [7:0]        drop_count_q;

  logic push_req, pop, range_drop, full_drop, push, drop;

  always_comb begin
    push_req   = videoflag & ~flag_q;
    pop        = (count_q != '0) & vram_ready;
    range_drop = push_req & (vga_pos > PosMax);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    full_drop  = push_req & ~range_drop & (count_q == FullCount) & ~pop;
    push       = push_req & ~range_drop & ~full_drop;
    drop       = range_drop | full_drop;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Start high so a strobe already asserted at reset release is not a write.
      flag_q       <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      range_err_q  <= 1'b0;
      drop_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pos_mem_q[i]  <= '0;
        char_mem_q[i] <= '0;
      end
    end else begin
      flag_q  <= videoflag;
      count_q <= count_d;
      if (push) begin
        pos_mem_q[wr_ptr_q]  <= vga_pos;
        char_mem_q[wr_ptr_q] <= vga_char;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (range_drop) begin
        range_err_q <= 1'b1;
      end
      if (full_drop) begin
        overflow_q <= 1'b1;
      end
      if (drop && drop_count_q != 8'hff) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign vram_addr  = pos_mem_q[rd_ptr_q];
  assign vram_data  = char_mem_q[rd_ptr_q];
  assign vram_we    = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign range_err  = range_err_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vga_write_bridge.sv
// Directed self-checking bench for vga_write_bridge with hand-computed expectations.
module tb_vga_write_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        videoflag;
  logic [15:0] vga_pos;
  logic [15:0] vga_char;
  logic [15:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_we;
  logic        vram_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        range_err;
  logic [7:0]  drop_count;

  int vectors = 0;
  int miscompares = 0;

  vga_write_bridge #(
    .DEPTH   (4),
    .POS_MAX (1199),
    .DATA_W  (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .videoflag  (videoflag),
    .vga_pos    (vga_pos),
    .vga_char   (vga_char),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_we    (vram_we),
    .vram_ready (vram_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .range_err  (range_err),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle strobe pulse; returns just after the edge that sampled it.
  task automatic strobe(input logic [15:0] pos, input logic [15:0] chr);
    videoflag = 1'b1;
    vga_pos   = pos;
    vga_char  = chr;
    tick();
    videoflag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    videoflag  = 1'b1;
    vga_pos    = '0;
    vga_char   = '0;
    vram_ready = 1'b1;
    #1;
    check("rst_we", vram_we, 0);
    check("rst_count", fifo_count, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_data", vram_data, 0);
    check("rst_flags", {overflow, range_err}, 0);
    check("rst_drop", drop_count, 0);

    // Strobe held high through reset release: no push.
    tick();
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vram_we !== 1'b0) check("held_we", vram_we, 0);
    end
    check("held_count", fifo_count, 0);
    videoflag = 1'b0;
    tick();
    strobe(16'd7, 16'h0a07);
    check("held_new_we", vram_we, 1);
    check("held_new_addr", vram_addr, 7);
    tick();
    check("held_new_we_off", vram_we, 0);

    // Single write.
    tick();
    strobe(16'd5, 16'h0741);
    check("single_we", vram_we, 1);
    check("single_addr", vram_addr, 5);
    check("single_data", vram_data, 16'h0741);
    check("single_count", fifo_count, 1);
    tick();
    check("single_we_off", vram_we, 0);
    check("single_count0", fifo_count, 0);

    // Backpressure and overflow.
    vram_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      strobe(16'(i), 16'h0100 + 16'(i));
      tick();
    end
    check("bp_count", fifo_count, 4);
    check("bp_overflow", overflow, 1);
    check("bp_drop", drop_count, 1);
    check("bp_stall_addr", vram_addr, 1);
    vram_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_we_%0d", i), vram_we, 1);
      check($sformatf("bp_addr_%0d", i), vram_addr, i);
      check($sformatf("bp_data_%0d", i), vram_data, 32'h0100 + i);
      tick();
    end
    check("bp_empty", vram_we, 0);

    // Full with simultaneous pop: push accepted.
    do_reset();
    vram_ready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      strobe(16'(i), 16'h0200 + 16'(i));
      tick();
    end
    check("fp_full", fifo_count, 4);
    vram_ready = 1'b1;
    strobe(16'd9, 16'h0209);
    check("fp_count", fifo_count, 4);
    check("fp_overflow", overflow, 0);
    check("fp_drop", drop_count, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp_addr_%0d", i), vram_addr, (i == 3) ? 9 : 11 + i);
      tick();
    end
    check("fp_empty", vram_we, 0);

    // Range check and drop_count saturation.
    strobe(16'd1200, 16'h1111);
    check("rng_we", vram_we, 0);
    check("rng_err", range_err, 1);
    check("rng_drop", drop_count, 1);
    check("rng_overflow", overflow, 0);
    tick();
    strobe(16'd1199, 16'h2222);
    check("rng_max_we", vram_we, 1);
    check("rng_max_addr", vram_addr, 1199);
    check("rng_max_drop", drop_count, 1);
    tick();
    vram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(16'(20 + i), 16'h0);
      tick();
    end
    for (int i = 0; i < 253; i++) begin
      strobe(16'd30, 16'h0);
      tick();
    end
    check("sat_254", drop_count, 254);
    for (int i = 0; i < 47; i++) begin
      strobe(16'd30, 16'h0);
      tick();
    end
    check("sat_255", drop_count, 255);
    check("sat_count", fifo_count, 4);
    check("sat_head", vram_addr, 20);

    // Async reset with pending entries.
    do_reset();
    vram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(16'(40 + i), 16'h0);
      tick();
    end
    check("ar_pending", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    check("ar_we", vram_we, 0);
    check("ar_count", fifo_count, 0);
    check("ar_drop", drop_count, 0);
    #1 reset = 1'b0;
    tick();
    vram_ready = 1'b1;
    strobe(16'd2, 16'h0333);
    check("ar_new_we", vram_we, 1);
    check("ar_new_addr", vram_addr, 2);
    check("ar_new_data", vram_data, 16'h0333);
    tick();
    check("ar_new_empty", vram_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_write_bridge.md
Name: vga_write_bridge

Overview:
- Consumer end of the CPU video-write interface: the CPU drives a character-write strobe with a screen position and a character word.
- This block detects each strobe and buffers the writes in a small FIFO.
- It then drains them into the video character RAM write port, using a valid/ready handshake.
- It sits between the CPU video outputs and the VGA character memory, on a single clock.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- POS_MAX, 1199, highest legal screen position (40x30 text screen); positions above it are rejected.
- DATA_W, 16, width of the position and character words.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- videoflag  input  1  CPU write strobe (level); one write per low-to-high transition.
- vga_pos  input  DATA_W  screen position, valid in the cycle the strobe edge is detected.
- vga_char  input  DATA_W  character/colour word, valid with vga_pos.
- vram_addr  output  DATA_W  write address to character RAM (FIFO head position).
- vram_data  output  DATA_W  write data to character RAM (FIFO head character).
- vram_we  output  1  write request (valid); high whenever the FIFO is non-empty.
- vram_ready  input  1  RAM accepts the write at a clock edge where vram_we=1.
- fifo_count  output  $clog2(DEPTH)+1  current number of occupied entries.
- overflow  output  1  sticky; set when a write is dropped because the FIFO is full.
- range_err  output  1  sticky; set when a write is dropped because vga_pos > POS_MAX.
- drop_count  output  8  saturating count of all dropped writes (either cause).

Behaviour:
- Reset (async, while reset=1):
  - vram_addr=0, vram_data=0, vram_we=0, fifo_count=0.
  - overflow=0, range_err=0, drop_count=0.
  - FIFO pointers=0.
  - Edge-detect register flag_d=1, so a strobe already high at reset release is not counted as a write.
- Strobe detect:
  - flag_d <= videoflag every cycle.
  - A push request occurs in the cycle where videoflag=1 and flag_d=0.
  - vga_pos and vga_char are sampled in that same cycle.
  - A strobe held high for many cycles produces exactly one push.
- Push rules, evaluated in priority order at the edge-detect cycle:
  1. vga_pos > POS_MAX (unsigned compare): discard; range_err<=1; drop_count+1 (saturate at 255); FIFO unchanged.
  2. fifo_count==DEPTH and no pop this cycle: discard; overflow<=1; drop_count+1 (saturate).
  3. Otherwise: write {pos,char} at the write pointer; write pointer +1 mod DEPTH.
- Pop: occurs at a clock edge where vram_we=1 and vram_ready=1; read pointer +1 mod DEPTH.
- Simultaneous push and pop: both happen and fifo_count is unchanged. This includes the full case, where the push is accepted.
- Output:
  - FIFO is show-ahead: vram_addr/vram_data always show the head entry.
  - vram_we = (fifo_count != 0).
  - Outputs hold stable while vram_we=1 and vram_ready=0.
- Latency:
  - Strobe edge sampled at edge N into an empty FIFO -> vram_we=1 with that entry's addr/data after edge N.
  - With vram_ready held high, it pops at edge N+1.
  - Sustained throughput is one write per cycle.
- Ordering: strict FIFO; RAM writes occur in strobe order.
- Pointers: each wraps modulo DEPTH. Full/empty is resolved by fifo_count, never by pointer equality alone.
- drop_count saturates at 255 and never wraps. Sticky flags clear only on reset.
- Reset mid-operation: all pending entries are discarded immediately and vram_we drops asynchronously. No partial write is issued after reset deasserts.

Test Plan:
- Single write: with vram_ready=1, strobe pos=5, char=0x0741 -> vram_we=1 for exactly one cycle, starting 1 cycle after the edge, with vram_addr=5, vram_data=0x0741; fifo_count returns to 0.
- Held strobe / reset release: videoflag high through reset release and held 10 cycles -> no push, vram_we stays 0. Then drop, re-raise with pos=7 -> exactly one write to addr 7.
- Backpressure and full: vram_ready=0, issue 5 strobes pos=1..5 (DEPTH=4) -> fifo_count=4, overflow=1, drop_count=1. Release ready -> writes to addr 1,2,3,4 in order, then vram_we=0.
- Full with simultaneous pop: FIFO full, vram_ready=1, strobe pos=9 on the same cycle -> push accepted, overflow stays 0, addr 9 is written last.
- Range check: strobe pos=1200 -> no write, range_err=1, drop_count increments; pos=1199 is accepted. Then 300 overflowing drops -> drop_count=255.
- Async reset with 3 entries pending and vram_ready=0 -> vram_we=0 immediately and fifo_count=0; after release a new strobe pos=2 is written first.
